// File: rtl/keypad_scanner.sv
// Bus-readable 4x4 matrix keypad scanner: row drive, column sampling, debounce, latched key code.
// Optional KPD_IRQ_EN adds a level interrupt output IRQ_O that mirrors DAT_O[15].
module keypad_scanner #(
  parameter int SCAN_TICKS     = 5000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RE_I,
  input  logic [3:0]  kpd_col,
  output logic [3:0]  kpd_row,
  output logic [15:0] DAT_O
`ifdef KPD_IRQ_EN
  ,
  output logic        IRQ_O
`endif
);

  localparam int CW = (SCAN_TICKS > 2) ? $clog2(SCAN_TICKS) : 1;
  localparam int SW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0] CNT_MAX    = CW'(SCAN_TICKS - 1);
  localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    row_idx_q, row_idx_d;
  logic [CW-1:0] cnt_q;
  logic [SW-1:0] stable_q, stable_d;
  logic [3:0]    code_q, code_d;
  logic [3:0]    key_q;
  logic          valid_q, overrun_q;

  logic          sample;
  logic          hit;
  logic [1:0]    col_idx;
  logic          latch;

  assign sample = (cnt_q == '0);

  // Exactly one column active is a key; none or several (ghosting) is treated as no key.
  always_comb begin
    hit     = 1'b1;
    col_idx = 2'd0;
    case (kpd_col)
      4'b0001: col_idx = 2'd0;
      4'b0010: col_idx = 2'd1;
      4'b0100: col_idx = 2'd2;
      4'b1000: col_idx = 2'd3;
      default: hit = 1'b0;
    endcase
  end

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    row_idx_d = row_idx_q;
    stable_d  = stable_q;
    code_d    = code_q;
    latch     = 1'b0;
    if (sample) begin
      case (state_q)
        SCAN: begin
          if (hit) begin
            code_d = {row_idx_q, col_idx};
            if (STABLE_MAX == SW'(1)) begin
              latch    = 1'b1;
              stable_d = '0;
              state_d  = HELD;
            end else begin
              stable_d = SW'(1);
              state_d  = DEBOUNCE;
            end
          end else begin
            row_idx_d = row_idx_q + 2'd1;
          end
        end
        DEBOUNCE: begin
          if (hit && (col_idx == code_q[1:0])) begin
            if (stable_q + SW'(1) == STABLE_MAX) begin
              latch    = 1'b1;
              stable_d = '0;
              state_d  = HELD;
            end else begin
              stable_d = stable_q + SW'(1);
            end
          end else begin
            stable_d  = '0;
            row_idx_d = row_idx_q + 2'd1;
            state_d   = SCAN;
          end
        end
        HELD: begin
          // Any column activity, even ghosted, keeps the key considered held.
          if (kpd_col == 4'b0000) begin
            if (stable_q + SW'(1) == STABLE_MAX) begin
              stable_d  = '0;
              row_idx_d = row_idx_q + 2'd1;
              state_d   = SCAN;
            end else begin
              stable_d = stable_q + SW'(1);
            end
          end else begin
            stable_d = '0;
          end
        end
        default: begin
          stable_d = '0;
          state_d  = SCAN;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= SCAN;
      row_idx_q <= 2'd0;
      cnt_q     <= CNT_MAX;
      stable_q  <= '0;
      code_q    <= 4'd0;
      key_q     <= 4'd0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_idx_q <= row_idx_d;
      stable_q  <= stable_d;
      code_q    <= code_d;
      cnt_q     <= sample ? CNT_MAX : cnt_q - CW'(1);
      // A latch takes priority over a simultaneous read acknowledge.
      if (latch) begin
        key_q     <= code_d;
        valid_q   <= 1'b1;
        overrun_q <= valid_q & ~RE_I;
      end else if (RE_I) begin
        valid_q   <= 1'b0;
        overrun_q <= 1'b0;
      end
    end
  end

  assign kpd_row = 4'b0001 << row_idx_q;
  assign DAT_O   = {valid_q, overrun_q, 10'b0, key_q};

`ifdef KPD_IRQ_EN
  assign IRQ_O = valid_q;
`endif

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner (SCAN_TICKS=4, DEBOUNCE_SCANS=3); DAT_O changes are scoreboarded.
// Define KPD_IRQ_EN for both files to also check IRQ_O.
module tb_keypad_scanner;

  localparam int ST = 4;
  localparam int DS = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        re;
  logic [3:0]  col;
  logic [3:0]  row;
  logic [15:0] dat;
`ifdef KPD_IRQ_EN
  logic        irq;
`endif

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];
  logic [15:0] prev_dat = 16'h0000;

  keypad_scanner #(.SCAN_TICKS(ST), .DEBOUNCE_SCANS(DS)) dut (
    .clk     (clk),
    .rst     (rst),
    .RE_I    (re),
    .kpd_col (col),
    .kpd_row (row),
    .DAT_O   (dat)
`ifdef KPD_IRQ_EN
    ,
    .IRQ_O   (irq)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Every change of DAT_O must match the next scoreboard entry.
  always @(negedge clk) begin
    if (dat !== prev_dat) begin
      if (exp_q.size() == 0) check("dat_unexpected", dat, prev_dat);
      else check("dat_sb", dat, exp_q.pop_front());
`ifdef KPD_IRQ_EN
      check("irq_level", {15'b0, irq}, {15'b0, dat[15]});
`endif
      prev_dat = dat;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns on the first negedge the row is driven (dwell counter just reloaded).
  task automatic wait_row(input logic [3:0] r);
    int n = 0;
    while (row !== r && n < 64) begin
      @(negedge clk);
      n++;
    end
    check("wait_row", {12'b0, row}, {12'b0, r});
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 64) begin
      @(negedge clk);
      n++;
    end
    check("sb_drain", 16'(exp_q.size()), 16'd0);
  endtask

  initial begin
    rst = 1'b1;
    re  = 1'b0;
    col = 4'b0000;
    cycles(2);
    check("rst_row", {12'b0, row}, 16'h0001);
    check("rst_dat", dat, 16'h0000);
`ifdef KPD_IRQ_EN
    check("rst_irq", {15'b0, irq}, 16'h0000);
`endif

    // 1) free-running row rotation, one row per ST cycles
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      check($sformatf("rotate_%0d", k), {12'b0, row}, {12'b0, 4'b0001 << ((k / ST) % 4)});
      @(negedge clk);
    end
    check("idle_dat", dat, 16'h0000);

    // 2) row1/col2 press, now first cycle of row 0010
    check("row1_start", {12'b0, row}, 16'h0002);
    col = 4'b0100;
    exp_q.push_back(16'h8006);
    cycles(4 * DS - 1);
    check("latency_early", dat, 16'h0000);
    cycles(1);
    check("latency", dat, 16'h8006);
    cycles(8);
    check("held_row", {12'b0, row}, 16'h0002);

    // 3) release, press row3/col0 before acknowledge -> overrun
    col = 4'b0000;
    wait_row(4'b0100);
    wait_row(4'b1000);
    col = 4'b0001;
    exp_q.push_back(16'hC00C);
    cycles(4 * DS);
    check("overrun", dat, 16'hC00C);
    exp_q.push_back(16'h000C);
    re = 1'b1;
    cycles(1);
    re = 1'b0;
    check("re_clear", dat, 16'h000C);
    col = 4'b0000;

    // 4) one-sample glitch on row0, then a ghosted pair of columns
    wait_row(4'b0001);
    col = 4'b0001;
    cycles(ST);
    col = 4'b0000;
    check("debounce_frozen", {12'b0, row}, 16'h0001);
    cycles(ST);
    check("glitch_rescan", {12'b0, row}, 16'h0002);
    check("glitch_dat", dat, 16'h000C);
    col = 4'b0011;
    cycles(ST);
    check("ghost_rotate", {12'b0, row}, 16'h0004);
    cycles(36);
    col = 4'b0000;
    check("ghost_dat", dat, 16'h000C);

    // 5) reset with stable=2, then a full debounce is needed again
    wait_row(4'b0001);
    col = 4'b0001;
    cycles(2 * ST);
    exp_q.push_back(16'h0000);
    #2 rst = 1'b1;
    #1;
    check("rst_async_row", {12'b0, row}, 16'h0001);
    check("rst_async_dat", dat, 16'h0000);
    col = 4'b0010;
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(16'h8001);
    cycles(4 * DS - 1);
    check("rearm_early", dat, 16'h0000);
    cycles(1);
    check("rearm", dat, 16'h8001);

    // 6) acknowledge in the latch cycle: latch wins, no overrun
    col = 4'b0000;
    wait_row(4'b0010);
    col = 4'b1000;
    cycles(4 * DS - 1);
    re = 1'b1;
    exp_q.push_back(16'h8007);
    cycles(1);
    re = 1'b0;
    check("latch_beats_re", dat, 16'h8007);
`ifdef KPD_IRQ_EN
    check("irq_stays", {15'b0, irq}, 16'h0001);
`endif
    exp_q.push_back(16'h0007);
    re = 1'b1;
    cycles(1);
    re = 1'b0;
    check("final_clear", dat, 16'h0007);
`ifdef KPD_IRQ_EN
    check("irq_cleared", {15'b0, irq}, 16'h0000);
`endif
    col = 4'b0000;

    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
